// File: rtl/bird_column_if.sv
// Control and display bundle between the bird column and its neighbours.
// The master drives the player/pipe inputs. The slave drives the light column.
interface bird_column_if #(
    parameter int NUM_ROWS = 8
) ();
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    logic                flap;
    logic                lose;
    logic                restart;
    logic [NUM_ROWS-1:0] position;
    logic [ROW_W-1:0]    row;
    logic                flying;
    logic                dead;

    modport master (
        output flap, lose, restart,
        input  position, row, flying, dead
    );

    modport slave (
        input  flap, lose, restart,
        output position, row, flying, dead
    );
endinterface

// File: rtl/bird_column.sv
// Holds the bird's row in a column of lights and runs the READY/FLY/DEAD life cycle.
// A flap edge raises the bird, a gravity timer lowers it, and a collision or ground strike kills it.
module bird_column #(
    parameter int NUM_ROWS    = 8,
    parameter int START_ROW   = 4,
    parameter int FLAP_RISE   = 1,
    parameter int FALL_PERIOD = 4
) (
    input  logic             clk,
    input  logic             reset,
    bird_column_if.slave     bus
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CNT_W = (FALL_PERIOD > 1) ? $clog2(FALL_PERIOD) : 1;

    localparam logic [ROW_W-1:0] START_IDX = ROW_W'(START_ROW);
    localparam logic [ROW_W-1:0] TOP_IDX   = ROW_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FALL_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_READY,
        ST_FLY,
        ST_DEAD
    } state_t;

    state_t           r_state;
    logic [ROW_W-1:0] r_row;
    logic [CNT_W-1:0] r_fall_cnt;
    logic             r_flap_q;

    state_t           w_state_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    logic [CNT_W-1:0] w_fall_cnt_nxt;
    logic             w_flap_edge;
    logic [ROW_W:0]   w_rise_sum;
    logic [ROW_W-1:0] w_rise_row;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_READY;
            r_row      <= START_IDX;
            r_fall_cnt <= '0;
            r_flap_q   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_fall_cnt <= w_fall_cnt_nxt;
            r_flap_q   <= bus.flap;
        end
    end

    // The extra sum bit keeps row+FLAP_RISE from wrapping before the clamp to the top light.
    always_comb begin
        w_flap_edge = bus.flap & ~r_flap_q;
        w_rise_sum  = {1'b0, r_row} + (ROW_W + 1)'(FLAP_RISE);
        w_rise_row  = (w_rise_sum > {1'b0, TOP_IDX}) ? TOP_IDX : w_rise_sum[ROW_W-1:0];
    end

    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_fall_cnt_nxt = r_fall_cnt;

        if (bus.restart) begin
            w_state_nxt    = ST_READY;
            w_row_nxt      = START_IDX;
            w_fall_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_READY: begin
                    w_fall_cnt_nxt = '0;
                    if (w_flap_edge) begin
                        w_state_nxt = ST_FLY;
                        w_row_nxt   = w_rise_row;
                    end
                end
                ST_FLY: begin
                    if (bus.lose) begin
                        w_state_nxt    = ST_DEAD;
                        w_fall_cnt_nxt = '0;
                    end else if (w_flap_edge) begin
                        w_row_nxt      = w_rise_row;
                        w_fall_cnt_nxt = '0;
                    end else if (r_fall_cnt == LAST_CNT) begin
                        w_fall_cnt_nxt = '0;
                        if (r_row != '0) begin
                            w_row_nxt = r_row - ROW_W'(1);
                        end else begin
                            w_state_nxt = ST_DEAD;
                        end
                    end else begin
                        w_fall_cnt_nxt = r_fall_cnt + CNT_W'(1);
                    end
                end
                ST_DEAD: begin
                    w_fall_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt    = ST_READY;
                    w_row_nxt      = START_IDX;
                    w_fall_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign bus.position = NUM_ROWS'(1) << r_row;
    assign bus.row      = r_row;
    assign bus.flying   = (r_state == ST_FLY);
    assign bus.dead     = (r_state == ST_DEAD);
endmodule

// File: tb/tb_bird_column.sv
// Self-checking bench for bird_column: a vector table plus hand sequences on three configurations.
// Expected outputs are queued as each cycle is driven and popped after the clock edge.
module tb_bird_column;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bird_column_if #(.NUM_ROWS(8))  ifa ();
    bird_column_if #(.NUM_ROWS(8))  ifb ();
    bird_column_if #(.NUM_ROWS(16)) ifc ();

    bird_column #(.NUM_ROWS(8), .START_ROW(4), .FLAP_RISE(1), .FALL_PERIOD(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    bird_column #(.NUM_ROWS(8), .START_ROW(4), .FLAP_RISE(3), .FALL_PERIOD(4)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));
    bird_column #(.NUM_ROWS(16), .START_ROW(0), .FLAP_RISE(1), .FALL_PERIOD(4)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc.slave));

    typedef struct {
        logic flap;
        logic lose;
        logic restart;
        int   row;
        logic fly;
        logic dead;
    } vec_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    // Observation word: {position[15:0], row[7:0], 6'b0, flying, dead}.
    function automatic logic [31:0] pack(input int row, input logic fly, input logic dead);
        logic [31:0] one_hot;
        one_hot = 32'd1 << row;
        return {one_hot[15:0], 8'(row), 6'b0, fly, dead};
    endfunction

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:       return {8'b0, ifa.position, 5'b0, ifa.row, 6'b0, ifa.flying, ifa.dead};
            1:       return {8'b0, ifb.position, 5'b0, ifb.row, 6'b0, ifb.flying, ifb.dead};
            default: return {ifc.position, 4'b0, ifc.row, 6'b0, ifc.flying, ifc.dead};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic f, input logic l, input logic r);
        case (sel)
            0:       begin ifa.flap = f; ifa.lose = l; ifa.restart = r; end
            1:       begin ifb.flap = f; ifb.lose = l; ifb.restart = r; end
            default: begin ifc.flap = f; ifc.lose = l; ifc.restart = r; end
        endcase
    endtask

    // One clock: drive on the falling edge, queue the expectation, compare just after the rising edge.
    task automatic step(input int sel, input logic f, input logic l, input logic r,
                        input int row, input logic fly, input logic dead, input string name);
        sb_t item;
        @(negedge clk);
        set_in(sel, f, l, r);
        sb.push_back('{sel: sel, exp: pack(row, fly, dead), name: name});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual=%h required=queued entry", name, obs(sel));
        end else begin
            item = sb.pop_front();
            check(item.name, obs(item.sel), item.exp);
        end
    endtask

    task automatic add(input logic f, input logic l, input logic r,
                       input int row, input logic fly, input logic dead, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{f, l, r, row, fly, dead});
    endtask

    initial begin
        // Configuration A (8/4/1/4) vector table, starting from reset.
        add(0, 0, 0, 4, 0, 0, 10);   // idle
        add(0, 1, 0, 4, 0, 0, 1);    // lose ignored in READY
        add(0, 0, 0, 4, 0, 0, 1);
        add(1, 0, 0, 5, 1, 0, 4);    // press and hold: row 5 for four cycles
        add(1, 0, 0, 4, 1, 0, 4);
        add(0, 0, 0, 3, 1, 0, 1);    // drop to 3 on the release cycle
        add(1, 1, 0, 3, 0, 1, 1);    // lose beats flap edge
        add(0, 0, 0, 3, 0, 1, 1);
        add(1, 0, 0, 3, 0, 1, 1);
        add(0, 1, 0, 3, 0, 1, 1);
        add(0, 0, 1, 4, 0, 0, 1);    // restart from DEAD
        add(1, 0, 1, 4, 0, 0, 1);    // flap edge discarded under restart
        add(1, 0, 0, 4, 0, 0, 1);    // flap still high: no edge
        add(0, 0, 0, 4, 0, 0, 1);
        add(1, 0, 0, 5, 1, 0, 1);
        add(0, 0, 1, 4, 0, 0, 1);    // restart from FLY
        add(1, 0, 0, 5, 1, 0, 1);    // free fall to the ground
        add(0, 0, 0, 5, 1, 0, 3);
        add(0, 0, 0, 4, 1, 0, 4);
        add(0, 0, 0, 3, 1, 0, 4);
        add(0, 0, 0, 2, 1, 0, 4);
        add(0, 0, 0, 1, 1, 0, 4);
        add(0, 0, 0, 0, 1, 0, 4);
        add(0, 0, 0, 0, 0, 1, 1);    // ground strike
        add(1, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 4, 0, 0, 1);

        set_in(0, 0, 0, 0);
        set_in(1, 0, 0, 0);
        set_in(2, 0, 0, 0);
        reset = 1'b1;
        #3;
        check("reset_a", obs(0), pack(4, 0, 0));
        check("reset_b", obs(1), pack(4, 0, 0));
        check("reset_c", obs(2), pack(0, 0, 0));
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(0, vecs[i].flap, vecs[i].lose, vecs[i].restart,
                 vecs[i].row, vecs[i].fly, vecs[i].dead, $sformatf("vec%0d", i));
        end

        // Climb to row 6, then reset between clock edges.
        step(0, 1, 0, 0, 5, 1, 0, "climb5");
        step(0, 0, 0, 0, 5, 1, 0, "climb5_hold");
        step(0, 1, 0, 0, 6, 1, 0, "climb6");
        #2;
        reset = 1'b1;
        set_in(0, 0, 0, 0);
        #1;
        check("async_reset_a", obs(0), pack(4, 0, 0));
        check("async_reset_c", obs(2), pack(0, 0, 0));
        @(negedge clk);
        reset = 1'b0;

        // 16-row column starting at row 0.
        step(2, 1, 0, 0, 1, 1, 0, "c_flap");
        step(2, 0, 0, 0, 1, 1, 0, "c_hold");

        // FLAP_RISE=3: reach row 6, then clamp at the top and restart the gravity timer.
        step(1, 1, 0, 0, 7, 1, 0, "b_rise");
        step(1, 0, 0, 0, 7, 1, 0, "b_fall1");
        step(1, 0, 0, 0, 7, 1, 0, "b_fall2");
        step(1, 0, 0, 0, 7, 1, 0, "b_fall3");
        step(1, 0, 0, 0, 6, 1, 0, "b_at6");
        step(1, 1, 0, 0, 7, 1, 0, "b_clamp");
        step(1, 0, 0, 0, 7, 1, 0, "b_gap");
        step(1, 1, 0, 0, 7, 1, 0, "b_top_flap");
        step(1, 0, 0, 0, 7, 1, 0, "b_cnt1");
        step(1, 0, 0, 0, 7, 1, 0, "b_cnt2");
        step(1, 0, 0, 0, 7, 1, 0, "b_cnt3");
        step(1, 0, 0, 0, 6, 1, 0, "b_drop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
